// File: rtl/team_06_echo_mem_ctrl.sv
// Echo delay-line sequencer: turns each search into a past-sample read and a sample write
// on the single-port sample SRAM, zero-fills the line after reset or on command.
module team_06_echo_mem_ctrl #(
    parameter int unsigned DEPTH_LOG2 = 13,
    parameter int unsigned DW         = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DEPTH_LOG2-1:0] delay_cfg,
    input  logic                  clear,
    input  logic                  search,
    input  logic [DW-1:0]         save_audio,
    output logic [DEPTH_LOG2-1:0] offset,
    output logic [DW-1:0]         past_output,
    output logic                  past_valid,
    output logic                  busy,
    output logic                  overrun,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DEPTH_LOG2-1:0] mem_addr,
    output logic [DW-1:0]         mem_wdata,
    input  logic [DW-1:0]         mem_rdata,
    input  logic                  mem_ack
);

    localparam int unsigned AW = DEPTH_LOG2;
    localparam logic [AW-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_RD,
        ST_WR
    } state_t;

    state_t        state, state_n;
    logic [AW-1:0] clr_ptr, clr_ptr_n;
    logic [AW-1:0] wr_ptr, wr_ptr_n;
    logic [DW-1:0] sample, sample_n;
    logic [AW-1:0] offset_n;
    logic [DW-1:0] past_output_n;
    logic          past_valid_n;
    logic          busy_n;
    logic          overrun_n;
    logic          mem_req_n;
    logic          mem_we_n;
    logic [AW-1:0] mem_addr_n;
    logic [DW-1:0] mem_wdata_n;

    // State and every output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_CLEAR;
            clr_ptr     <= '0;
            wr_ptr      <= '0;
            sample      <= '0;
            offset      <= '0;
            past_output <= '0;
            past_valid  <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            state       <= state_n;
            clr_ptr     <= clr_ptr_n;
            wr_ptr      <= wr_ptr_n;
            sample      <= sample_n;
            offset      <= offset_n;
            past_output <= past_output_n;
            past_valid  <= past_valid_n;
            busy        <= busy_n;
            overrun     <= overrun_n;
            mem_req     <= mem_req_n;
            mem_we      <= mem_we_n;
            mem_addr    <= mem_addr_n;
            mem_wdata   <= mem_wdata_n;
        end
    end

    // Next state and next register values.
    always_comb begin
        state_n       = state;
        clr_ptr_n     = clr_ptr;
        wr_ptr_n      = wr_ptr;
        sample_n      = sample;
        offset_n      = offset;
        past_output_n = past_output;
        past_valid_n  = 1'b0;
        overrun_n     = overrun;
        mem_req_n     = mem_req;
        mem_we_n      = mem_we;
        mem_addr_n    = mem_addr;
        mem_wdata_n   = mem_wdata;

        if (search && (state != ST_IDLE)) begin
            overrun_n = 1'b1;
        end

        case (state)
            ST_CLEAR: begin
                if (!mem_req) begin
                    mem_req_n   = 1'b1;
                    mem_we_n    = 1'b1;
                    mem_addr_n  = clr_ptr;
                    mem_wdata_n = '0;
                end else if (mem_ack) begin
                    mem_req_n   = 1'b0;
                    mem_we_n    = 1'b0;
                    mem_addr_n  = '0;
                    if (clr_ptr == LAST_ADDR) begin
                        state_n  = ST_IDLE;
                        wr_ptr_n = '0;
                        offset_n = delay_cfg;
                    end else begin
                        clr_ptr_n = clr_ptr + AW'(1);
                    end
                end
            end
            ST_IDLE: begin
                if (clear) begin
                    state_n   = ST_CLEAR;
                    clr_ptr_n = '0;
                    overrun_n = 1'b0;
                    offset_n  = delay_cfg;
                end else if (search) begin
                    // offset stays frozen so the read address matches the offset on display
                    sample_n  = save_audio;
                    mem_req_n = 1'b1;
                    if (offset == '0) begin
                        state_n       = ST_WR;
                        past_output_n = '0;
                        past_valid_n  = 1'b1;
                        mem_we_n      = 1'b1;
                        mem_addr_n    = wr_ptr;
                        mem_wdata_n   = save_audio;
                    end else begin
                        state_n    = ST_RD;
                        mem_we_n   = 1'b0;
                        mem_addr_n = wr_ptr - offset;
                    end
                end else begin
                    offset_n = delay_cfg;
                end
            end
            ST_RD: begin
                if (mem_ack) begin
                    state_n       = ST_WR;
                    past_output_n = mem_rdata;
                    past_valid_n  = 1'b1;
                    mem_we_n      = 1'b1;
                    mem_addr_n    = wr_ptr;
                    mem_wdata_n   = sample;
                end
            end
            ST_WR: begin
                if (mem_ack) begin
                    state_n     = ST_IDLE;
                    wr_ptr_n    = wr_ptr + AW'(1);
                    mem_req_n   = 1'b0;
                    mem_we_n    = 1'b0;
                    mem_addr_n  = '0;
                    mem_wdata_n = '0;
                end
            end
            default: begin
                state_n = ST_CLEAR;
            end
        endcase

        busy_n = (state_n != ST_IDLE);
    end

endmodule

// File: tb/tb_team_06_echo_mem_ctrl.sv
// Bench for the echo delay-line controller: transaction-level model with a shadow delay line,
// a latency-randomised SRAM responder and a per-cycle output compare.
module tb_team_06_echo_mem_ctrl;

    localparam int unsigned AW    = 13;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 8192;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] delay_cfg;
    logic          clear;
    logic          search;
    logic [DW-1:0] save_audio;
    logic [AW-1:0] offset;
    logic [DW-1:0] past_output;
    logic          past_valid;
    logic          busy;
    logic          overrun;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;

    always #5 clk = ~clk;

    team_06_echo_mem_ctrl #(.DEPTH_LOG2(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .delay_cfg  (delay_cfg),
        .clear      (clear),
        .search     (search),
        .save_audio (save_audio),
        .offset     (offset),
        .past_output(past_output),
        .past_valid (past_valid),
        .busy       (busy),
        .overrun    (overrun),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    function automatic txn_t mk(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        txn_t t;
        t.we   = we;
        t.addr = addr;
        t.data = data;
        return t;
    endfunction

    // SRAM responder with configurable ack latency
    logic [DW-1:0] mem [DEPTH];
    int lat_max  = 0;
    bit hold_ack = 1'b0;
    int wcnt     = 0;
    int cur_lat  = 0;
    int wr_log[$];
    int rd_log[$];
    int pv_log[$];

    initial for (int i = 0; i < int'(DEPTH); i++) mem[i] = 8'($urandom);

    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (!rst_n) begin
            wcnt = 0;
        end else if (mem_req && !hold_ack) begin
            if (wcnt >= cur_lat) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    wr_log.push_back(int'(mem_addr));
                end else begin
                    mem_rdata = mem[mem_addr];
                    rd_log.push_back(int'(mem_addr));
                end
                wcnt    = 0;
                cur_lat = int'($urandom_range(0, lat_max));
            end else begin
                wcnt++;
            end
        end
    end

    // Reference model: expected memory traffic queue plus a shadow copy of the delay line
    txn_t          exp_q[$];
    logic [DW-1:0] shadow [DEPTH];
    int            m_mode;   // 0 clearing, 1 idle, 2 search in flight
    logic [AW-1:0] m_offset, m_wp, m_raddr;
    logic [DW-1:0] m_past, m_rd_exp;
    logic          m_overrun, m_pv, m_req, m_busy;

    always @(posedge clk or negedge rst_n) begin : model
        txn_t t;
        bit   acked;
        int   start_mode;
        if (!rst_n) begin
            exp_q.delete();
            for (int i = 0; i < int'(DEPTH); i++) exp_q.push_back(mk(1'b1, AW'(i), '0));
            m_mode = 0; m_offset = '0; m_wp = '0; m_past = '0; m_rd_exp = '0;
            m_overrun = 1'b0; m_pv = 1'b0; m_req = 1'b0; m_busy = 1'b0;
        end else begin
            acked      = (mem_ack === 1'b1) && m_req;
            start_mode = m_mode;
            m_pv       = 1'b0;
            if (start_mode != 1 && search) m_overrun = 1'b1;
            if (start_mode == 0 && !m_req && exp_q.size() > 0) m_req = 1'b1;
            if (acked) begin
                t = exp_q.pop_front();
                if (!t.we) begin
                    m_pv   = 1'b1;
                    m_past = m_rd_exp;
                end else begin
                    m_req = 1'b0;
                    if (exp_q.size() == 0) begin
                        if (start_mode == 0) begin
                            m_wp     = '0;
                            m_offset = delay_cfg;
                            for (int i = 0; i < int'(DEPTH); i++) shadow[i] = '0;
                        end
                        m_mode = 1;
                    end
                end
            end
            if (start_mode == 1) begin
                if (clear) begin
                    m_mode    = 0;
                    m_overrun = 1'b0;
                    m_offset  = delay_cfg;
                    for (int i = 0; i < int'(DEPTH); i++) exp_q.push_back(mk(1'b1, AW'(i), '0));
                end else if (search) begin
                    m_mode = 2;
                    m_req  = 1'b1;
                    if (m_offset == '0) begin
                        m_pv   = 1'b1;
                        m_past = '0;
                    end else begin
                        m_raddr  = m_wp - m_offset;
                        m_rd_exp = shadow[m_raddr];
                        exp_q.push_back(mk(1'b0, m_raddr, '0));
                    end
                    exp_q.push_back(mk(1'b1, m_wp, save_audio));
                    shadow[m_wp] = save_audio;
                    m_wp = m_wp + AW'(1);
                end else begin
                    m_offset = delay_cfg;
                end
            end
            m_busy = (m_mode != 1);
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("offset", 32'(offset), 32'(m_offset));
            chk("overrun", 32'(overrun), 32'(m_overrun));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("past_valid", 32'(past_valid), 32'(m_pv));
            chk("past_output", 32'(past_output), 32'(m_past));
            chk("mem_req", 32'(mem_req), 32'(m_req));
            if (past_valid) pv_log.push_back(int'(past_output));
            if (mem_req) begin
                chk("txn_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    chk("mem_we", 32'(mem_we), 32'(exp_q[0].we));
                    chk("mem_addr", 32'(mem_addr), 32'(exp_q[0].addr));
                    if (exp_q[0].we) chk("mem_wdata", 32'(mem_wdata), 32'(exp_q[0].data));
                end
            end
        end
    end

    task automatic clear_logs();
        wr_log.delete();
        rd_log.delete();
        pv_log.delete();
    endtask

    task automatic wait_idle(input string name, input int max_cycles);
        bit ok = 1'b0;
        @(negedge clk);
        for (int i = 0; i < max_cycles; i++) begin
            if (!busy && !mem_req) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk({"timeout_", name}, 32'd0, 32'd1);
    endtask

    task automatic pulse_search(input logic [DW-1:0] s);
        search     = 1'b1;
        save_audio = s;
        @(negedge clk);
        search     = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int            nbad;
        logic [DW-1:0] s, prev_s;
        rst_n = 1'b1; search = 1'b0; clear = 1'b0; save_audio = '0; delay_cfg = 13'd5;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_offset", 32'(offset), 32'd0);
        chk("rst_past_output", 32'(past_output), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_past_valid", 32'(past_valid), 32'd0);
        rst_n = 1'b1;

        // Initial zero sweep with immediate acks
        clear_logs();
        wait_idle("clear1", 20000);
        chk("clear_count", 32'(wr_log.size()), 32'd8192);
        nbad = 0;
        foreach (wr_log[i]) if (wr_log[i] != i) nbad++;
        chk("clear_order", 32'(nbad), 32'd0);
        nbad = 0;
        for (int i = 0; i < int'(DEPTH); i++) if (mem[i] != 8'h00) nbad++;
        chk("clear_zero", 32'(nbad), 32'd0);
        chk("offset_after_clear", 32'(offset), 32'd5);

        // Delay 3, four samples spaced four cycles
        delay_cfg = 13'd3;
        repeat (2) @(negedge clk);
        clear_logs();
        pulse_search(8'd10); repeat (3) @(negedge clk);
        pulse_search(8'd20); repeat (3) @(negedge clk);
        pulse_search(8'd30); repeat (3) @(negedge clk);
        pulse_search(8'd40); repeat (3) @(negedge clk);
        wait_idle("four", 50);
        chk("four_pv_count", 32'(pv_log.size()), 32'd4);
        if (pv_log.size() == 4) begin
            chk("four_past0", 32'(pv_log[0]), 32'd0);
            chk("four_past1", 32'(pv_log[1]), 32'd0);
            chk("four_past2", 32'(pv_log[2]), 32'd0);
            chk("four_past3", 32'(pv_log[3]), 32'd10);
        end
        chk("four_wr_count", 32'(wr_log.size()), 32'd4);
        if (wr_log.size() == 4) begin
            chk("four_wr0", 32'(wr_log[0]), 32'd0);
            chk("four_wr3", 32'(wr_log[3]), 32'd3);
        end

        // Delay 1, run the write pointer around the wrap at minimum spacing
        delay_cfg = 13'd1;
        repeat (2) @(negedge clk);
        clear_logs();
        s = '0; prev_s = '0;
        for (int i = 0; i < 8189; i++) begin
            prev_s = s;
            s = 8'($urandom);
            pulse_search(s);
            repeat (2) @(negedge clk);
        end
        wait_idle("wrap", 50);
        chk("wrap_rd_count", 32'(rd_log.size()), 32'd8189);
        chk("wrap_last_rd", 32'(rd_log[$]), 32'd8191);
        chk("wrap_last_wr", 32'(wr_log[$]), 32'd0);
        chk("wrap_last_past", 32'(pv_log[$]), 32'(prev_s));
        chk("wrap_no_overrun", 32'(overrun), 32'd0);

        // Stalled read with a search arriving meanwhile
        delay_cfg = 13'd2;
        repeat (2) @(negedge clk);
        clear_logs();
        hold_ack = 1'b1;
        pulse_search(8'h55);
        @(negedge clk);
        pulse_search(8'h66);
        repeat (2) @(negedge clk);
        chk("stall_rd_addr", 32'(mem_addr), 32'd8191);
        chk("stall_req", 32'(mem_req), 32'd1);
        chk("stall_overrun", 32'(overrun), 32'd1);
        hold_ack = 1'b0;
        wait_idle("stall", 50);
        chk("stall_wr_count", 32'(wr_log.size()), 32'd1);
        chk("stall_wr_addr", 32'(wr_log[0]), 32'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear_resets_overrun", 32'(overrun), 32'd0);
        wait_idle("clear2", 20000);

        // Zero delay: no read, zero past sample, write still happens
        delay_cfg = 13'd0;
        repeat (2) @(negedge clk);
        clear_logs();
        pulse_search(8'h77);
        wait_idle("zero", 50);
        chk("zero_no_read", 32'(rd_log.size()), 32'd0);
        chk("zero_pv_count", 32'(pv_log.size()), 32'd1);
        chk("zero_wr_count", 32'(wr_log.size()), 32'd1);
        chk("zero_mem0", 32'(mem[0]), 32'h77);
        hold_ack = 1'b1;
        pulse_search(8'h88);
        delay_cfg = 13'd7;
        repeat (2) @(negedge clk);
        chk("offset_frozen", 32'(offset), 32'd0);
        hold_ack = 1'b0;
        wait_idle("frozen", 50);
        @(negedge clk);
        chk("offset_reloaded", 32'(offset), 32'd7);

        // Random traffic with random ack latency and delay changes
        lat_max = 3;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0:       delay_cfg = 13'd0;
                    1:       delay_cfg = 13'($urandom_range(1, 8));
                    default: delay_cfg = 13'($urandom);
                endcase
            end
            pulse_search(8'($urandom));
            repeat ($urandom_range(0, 7)) @(negedge clk);
        end
        wait_idle("random", 100);
        lat_max = 0;

        // Reset in the middle of a write
        delay_cfg = 13'd0;
        repeat (2) @(negedge clk);
        hold_ack = 1'b1;
        pulse_search(8'h99);
        chk("pre_rst_in_wr", 32'({mem_req, mem_we}), 32'b11);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_req", 32'(mem_req), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        hold_ack = 1'b0;
        clear_logs();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        chk("restart_some_writes", 32'(wr_log.size() > 100), 32'd1);
        if (wr_log.size() > 0) chk("restart_addr0", 32'(wr_log[0]), 32'd0);
        nbad = 0;
        foreach (wr_log[i]) if (wr_log[i] != i) nbad++;
        chk("restart_order", 32'(nbad), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
